// File: rtl/kx9016_pkg.sv
// Shared KX9016 datapath definitions: shift opcodes and sequencer state encoding.
// Both the datapath shift unit and the multi-cycle shifter decode these opcodes.
package kx9016_pkg;

  typedef logic [2:0] opcode_t;

  localparam opcode_t SHFTPASS = 3'd0;
  localparam opcode_t SFTL     = 3'd1;
  localparam opcode_t SFTR     = 3'd2;
  localparam opcode_t ROTL     = 3'd3;
  localparam opcode_t ROTR     = 3'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Opcodes that move bits; pass and the reserved codes 5-7 do not.
  function automatic logic is_move_op(input opcode_t op);
    return (op >= SFTL) && (op <= ROTR);
  endfunction

endpackage

// File: rtl/sft_step.sv
// Single-bit shift/rotate step, same opcode encoding as the datapath shift unit.
// Pass and reserved opcodes return the word unchanged with no bit shifted out.
module sft_step
  import kx9016_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  opcode_t          op,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             out_bit
);

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    q       = d;
    out_bit = 1'b0;
    unique case (op)
      SFTL: begin
        q       = {d[WIDTH-2:0], 1'b0};
        out_bit = d[WIDTH-1];
      end
      SFTR: begin
        q       = {1'b0, d[WIDTH-1:1]};
        out_bit = d[0];
      end
      ROTL: begin
        q       = {d[WIDTH-2:0], d[WIDTH-1]};
        out_bit = d[WIDTH-1];
      end
      ROTR: begin
        q       = {d[0], d[WIDTH-1:1]};
        out_bit = d[0];
      end
      default: begin
        q       = d;
        out_bit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/sft_seq.sv
// Sequential multi-position shifter: one single-bit step per clock, then a
// one-cycle done pulse. Operand, opcode and count are latched on an accepted start.
module sft_seq
  import kx9016_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNTW  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [2:0]       sel,
  input  logic [CNTW-1:0]  cnt,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             cout_q, cout_d;
  logic             zero_q;
  opcode_t          op_q, op_d;
  logic [CNTW-1:0]  rem_q, rem_d;

  logic [WIDTH-1:0] step_q;
  logic             step_out;

  sft_step #(.WIDTH(WIDTH)) u_step (
    .op      (op_q),
    .d       (y_q),
    .q       (step_q),
    .out_bit (step_out)
  );

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    cout_d  = cout_q;
    op_d    = op_q;
    rem_d   = rem_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d   = sel;
          rem_d  = cnt;
          cout_d = 1'b0;
          // Reserved opcodes finish immediately with a cleared result.
          y_d    = (sel > ROTR) ? '0 : a;
          if (is_move_op(sel) && (cnt != '0)) state_d = SHIFT;
          else                                state_d = DONE;
        end
      end
      SHIFT: begin
        y_d    = step_q;
        cout_d = step_out;
        rem_d  = rem_q - 1'b1;
        if (rem_q == CNTW'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registers update with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      y_q     <= '0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b1;
      op_q    <= SHFTPASS;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      cout_q  <= cout_d;
      zero_q  <= (y_d == '0);
      op_q    <= op_d;
      rem_q   <= rem_d;
    end
  end

  assign y    = y_q;
  assign cout = cout_q;
  assign zero = zero_q;
  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_sft_seq.sv
// Self-checking bench for sft_seq: directed corner cases plus randomized
// operations compared against an arithmetic shift/rotate reference model.
module tb_sft_seq;

  localparam int W = 16;

  logic          clock;
  logic          reset;
  logic          start;
  logic [W-1:0]  a;
  logic [2:0]    sel;
  logic [3:0]    cnt;
  logic [W-1:0]  y;
  logic          cout;
  logic          zero;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_pass   = 0;

  sft_seq #(.WIDTH(W), .CNTW(4)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .a     (a),
    .sel   (sel),
    .cnt   (cnt),
    .y     (y),
    .cout  (cout),
    .zero  (zero),
    .busy  (busy),
    .done  (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Whole-word reference: shift by n positions in one arithmetic step.
  function automatic void model(input logic [15:0] ta, input logic [2:0] ts, input logic [3:0] tn,
                                output logic [15:0] ey, output logic ec, output int ebusy);
    logic [31:0] w;
    logic [31:0] r;
    int n;
    w = {16'h0, ta};
    n = int'(tn);
    r = w;
    ec = 1'b0;
    case (ts)
      3'd1: begin r = (w << n) & 32'hFFFF;                  if (n > 0) ec = w[16-n]; end
      3'd2: begin r = w >> n;                               if (n > 0) ec = w[n-1];  end
      3'd3: begin r = ((w << n) | (w >> (16 - n))) & 32'hFFFF; if (n > 0) ec = r[0];   end
      3'd4: begin r = ((w >> n) | (w << (16 - n))) & 32'hFFFF; if (n > 0) ec = r[15];  end
      3'd0: r = w;
      default: r = 32'h0;
    endcase
    ey    = r[15:0];
    ebusy = (ts >= 3'd1 && ts <= 3'd4) ? n : 0;
  endfunction

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
  task automatic do_op(input string tag, input logic [15:0] ta, input logic [2:0] ts,
                       input logic [3:0] tn, input bit noise);
    logic [15:0] ey;
    logic        ec;
    int          ebusy;
    int          busy_n;
    int          guard;
    model(ta, ts, tn, ey, ec, ebusy);
    a = ta; sel = ts; cnt = tn; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    busy_n = 0;
    guard  = 0;
    while (!done && guard < 40) begin
      if (busy) busy_n++;
      a   = W'($urandom);
      sel = 3'($urandom);
      cnt = 4'($urandom);
      if (noise) start = 1'($urandom);
      @(posedge clock); #1;
      guard++;
    end
    start = 1'b0;
    check({tag, ".done"},  {31'h0, done}, 32'h1);
    check({tag, ".busyn"}, busy_n, ebusy);
    check({tag, ".y"},     {16'h0, y}, {16'h0, ey});
    check({tag, ".cout"},  {31'h0, cout}, {31'h0, ec});
    check({tag, ".zero"},  {31'h0, zero}, {31'h0, (ey == 16'h0)});
    @(posedge clock); #1;
    check({tag, ".pulse"}, {31'h0, done}, 32'h0);
    check({tag, ".hold"},  {16'h0, y}, {16'h0, ey});
  endtask

  int done_seen;

  initial begin
    reset = 1'b0; start = 1'b0; a = '0; sel = '0; cnt = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst.y",    {16'h0, y}, 32'h0);
    check("rst.cout", {31'h0, cout}, 32'h0);
    check("rst.zero", {31'h0, zero}, 32'h1);
    check("rst.busy", {31'h0, busy}, 32'h0);
    check("rst.done", {31'h0, done}, 32'h0);
    reset = 1'b1;
    @(posedge clock); #1;

    do_op("sftl4",  16'h0001, 3'd1, 4'd4,  1'b0);
    do_op("rotr1",  16'h0001, 3'd4, 4'd1,  1'b0);
    do_op("rotl0",  16'h8001, 3'd3, 4'd0,  1'b0);
    do_op("sftr15", 16'hFFFF, 3'd2, 4'd15, 1'b0);
    do_op("sftl15", 16'hFFFF, 3'd1, 4'd15, 1'b0);
    do_op("inv6",   16'hFFFF, 3'd6, 4'd3,  1'b0);
    do_op("pass",   16'hA5A5, 3'd0, 4'd9,  1'b0);
    do_op("rotr15", 16'h8001, 3'd4, 4'd15, 1'b1);

    // Start re-asserted mid-shift must be ignored.
    a = 16'h1234; sel = 3'd3; cnt = 4'd8; start = 1'b1;
    @(posedge clock); #1;                                  // E0
    start = 1'b0;
    @(posedge clock); #1;                                  // E1
    a = 16'hBEEF; sel = 3'd1; cnt = 4'd2; start = 1'b1;
    @(posedge clock); #1;                                  // E2
    start = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 20 && done_seen == 0; i++) begin
      if (done) done_seen = 1;
      else begin @(posedge clock); #1; end
    end
    check("ign.done", done_seen, 1);
    check("ign.y",    {16'h0, y}, 32'h3412);
    @(posedge clock); #1;

    // Reset mid-shift discards the operation.
    a = 16'h1234; sel = 3'd3; cnt = 4'd8; start = 1'b1;
    @(posedge clock); #1;                                  // E0
    start = 1'b0;
    @(posedge clock); #1;                                  // E1
    a = 16'hBEEF; start = 1'b1;
    @(posedge clock); #1;                                  // E2
    start = 1'b0; reset = 1'b0;
    @(posedge clock); #1;                                  // E3
    check("mrst.y",    {16'h0, y}, 32'h0);
    check("mrst.zero", {31'h0, zero}, 32'h1);
    check("mrst.cout", {31'h0, cout}, 32'h0);
    check("mrst.busy", {31'h0, busy}, 32'h0);
    reset = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (done || busy) done_seen++;
      @(posedge clock); #1;
    end
    check("mrst.quiet", done_seen, 0);

    for (int i = 0; i < 40; i++) begin
      do_op("rand", 16'($urandom), 3'($urandom_range(0, 7)), 4'($urandom), 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
